// File: rtl/reg_writeback.sv
// reg_writeback: writeback arbiter and destination scoreboard for a
// 2**AW-entry register file.
//
// Two producers (ALU = source 0, LSU = source 1) each hand results over a
// valid/ready handshake into a one-entry hold buffer. Buffered results are
// arbitrated round-robin onto a registered write port. A per-register
// scoreboard tracks destinations that have been issued but not yet written
// back, so the issue stage can stall on read-after-write hazards.
//
// Optional feature, macro WB_BYPASS_EN: adds fwd_a/fwd_b forwarding outputs
// that present the data being committed this cycle. When it is enabled, the
// commit-cycle term is dropped from busy_a/busy_b. The default build (macro
// undefined) has no forwarding ports.
module reg_writeback #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [AW-1:0]   lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    output logic [AW-1:0]   waddr,
    output logic [XLEN-1:0] wdata,
    output logic            reg_we,
    input  logic [AW-1:0]   query_a,
    input  logic [AW-1:0]   query_b,
    output logic            busy_a,
    output logic            busy_b,
`ifdef WB_BYPASS_EN
    output logic            fwd_a_valid,
    output logic [XLEN-1:0] fwd_a_data,
    output logic            fwd_b_valid,
    output logic [XLEN-1:0] fwd_b_data,
`endif
    output logic            idle
);

    localparam int NREG = 2 ** AW;
    localparam int NSRC = 2;

    // Producer inputs gathered into arrays (index 0 = ALU, 1 = LSU).
    logic [NSRC-1:0] in_valid;
    logic [AW-1:0]   in_rd   [NSRC];
    logic [XLEN-1:0] in_data [NSRC];
    logic [NSRC-1:0] in_ready;

    // Hold buffers, one entry per producer.
    logic [NSRC-1:0] hold_valid_q, hold_valid_d;
    logic [AW-1:0]   hold_rd_q   [NSRC];
    logic [AW-1:0]   hold_rd_d   [NSRC];
    logic [XLEN-1:0] hold_data_q [NSRC];
    logic [XLEN-1:0] hold_data_d [NSRC];

    // Round-robin pointer: 1 when the LSU was the most recent winner.
    // It resets to 0 so that the LSU wins the first contention.
    logic last_lsu_q, last_lsu_d;

    // Arbitration result for the current cycle.
    logic [NSRC-1:0] grant;
    logic            commit;
    logic [AW-1:0]   grant_rd;
    logic [XLEN-1:0] grant_data;

    // Registered write port.
    logic [AW-1:0]   waddr_q, waddr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic            reg_we_q, reg_we_d;

    // Scoreboard of in-flight destinations.
    logic [NREG-1:0] scoreboard_q, scoreboard_d;
    logic [NREG-1:0] sb_set;
    logic [NREG-1:0] sb_clr;
    logic            issue_set;

    // Hazard lookup helpers.
    logic hit_a, hit_b;
    logic nz_a, nz_b;

    assign in_valid   = {lsu_valid, alu_valid};
    assign in_rd[0]   = alu_rd;
    assign in_rd[1]   = lsu_rd;
    assign in_data[0] = alu_data;
    assign in_data[1] = lsu_data;

    assign alu_ready  = in_ready[0];
    assign lsu_ready  = in_ready[1];

    // Round-robin grant between the two hold buffers, plus pointer update.
    always_comb begin
        grant      = '0;
        last_lsu_d = last_lsu_q;
        if (run) begin
            if (hold_valid_q[0] && hold_valid_q[1]) begin
                // Both contending: the source that did not win last time goes.
                if (last_lsu_q) begin
                    grant[0] = 1'b1;
                end else begin
                    grant[1] = 1'b1;
                end
            end else begin
                // Zero or one contender: it wins outright.
                grant = hold_valid_q;
            end
        end
        if (grant[1]) begin
            last_lsu_d = 1'b1;
        end else if (grant[0]) begin
            last_lsu_d = 1'b0;
        end
    end

    assign commit     = |grant;
    assign grant_rd   = grant[1] ? hold_rd_q[1]   : hold_rd_q[0];
    assign grant_data = grant[1] ? hold_data_q[1] : hold_data_q[0];

    // Hold-buffer handshake: a granted slot can be refilled in the same cycle,
    // and a result addressed to register 0 is accepted but dropped.
    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            in_ready[i]     = run & (~hold_valid_q[i] | grant[i]);
            hold_valid_d[i] = hold_valid_q[i] & ~grant[i];
            hold_rd_d[i]    = hold_rd_q[i];
            hold_data_d[i]  = hold_data_q[i];
            if (in_valid[i] && in_ready[i] && (in_rd[i] != '0)) begin
                hold_valid_d[i] = 1'b1;
                hold_rd_d[i]    = in_rd[i];
                hold_data_d[i]  = in_data[i];
            end
        end
    end

    // Write port: load the granted entry; the enable only follows a grant.
    always_comb begin
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        reg_we_d = commit;
        if (commit) begin
            waddr_d = grant_rd;
            wdata_d = grant_data;
        end
    end

    // Issue is ignored while frozen; register 0 is never tracked.
    assign issue_set = run & issue_valid & (issue_rd != '0);

    // Per-register set/clear decode of the scoreboard.
    for (genvar gi = 0; gi < NREG; gi++) begin : g_sb
        assign sb_set[gi] = issue_set & (issue_rd == AW'(gi));
        assign sb_clr[gi] = commit & (grant_rd == AW'(gi));
    end

    // Scoreboard update: clear on commit, but a same-edge issue keeps it set.
    always_comb begin
        scoreboard_d = (scoreboard_q & ~sb_clr) | sb_set;
    end

    // All state registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hold_valid_q <= '0;
            for (int i = 0; i < NSRC; i++) begin
                hold_rd_q[i]   <= '0;
                hold_data_q[i] <= '0;
            end
            last_lsu_q   <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            reg_we_q     <= 1'b0;
            scoreboard_q <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            for (int i = 0; i < NSRC; i++) begin
                hold_rd_q[i]   <= hold_rd_d[i];
                hold_data_q[i] <= hold_data_d[i];
            end
            last_lsu_q   <= last_lsu_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            reg_we_q     <= reg_we_d;
            scoreboard_q <= scoreboard_d;
        end
    end

    assign waddr  = waddr_q;
    assign wdata  = wdata_q;
    assign reg_we = reg_we_q;

    // A query matches the write currently on the port (not yet in the file).
    assign hit_a = reg_we_q & (waddr_q == query_a);
    assign hit_b = reg_we_q & (waddr_q == query_b);
    assign nz_a  = (query_a != '0);
    assign nz_b  = (query_b != '0);

`ifdef WB_BYPASS_EN
    // Readers forward the committing value instead of stalling on it.
    assign busy_a      = scoreboard_q[query_a] & nz_a;
    assign busy_b      = scoreboard_q[query_b] & nz_b;
    assign fwd_a_valid = hit_a & nz_a;
    assign fwd_b_valid = hit_b & nz_b;
    assign fwd_a_data  = wdata_q;
    assign fwd_b_data  = wdata_q;
`else
    // The commit cycle still counts as busy: the file has not been written.
    assign busy_a = (scoreboard_q[query_a] | hit_a) & nz_a;
    assign busy_b = (scoreboard_q[query_b] | hit_b) & nz_b;
`endif

    assign idle = ~(|hold_valid_q) & ~(|scoreboard_q) & ~reg_we_q;

endmodule

// File: tb/tb_reg_writeback.sv
// Directed testbench for reg_writeback. Inputs change 1 time unit after a
// rising edge; outputs are checked 1 further unit later, well clear of edges.
module tb_reg_writeback;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic            clk;
    logic            reset;
    logic            run;
    logic            issue_valid;
    logic [AW-1:0]   issue_rd;
    logic            alu_valid;
    logic            alu_ready;
    logic [AW-1:0]   alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            lsu_valid;
    logic            lsu_ready;
    logic [AW-1:0]   lsu_rd;
    logic [XLEN-1:0] lsu_data;
    logic [AW-1:0]   waddr;
    logic [XLEN-1:0] wdata;
    logic            reg_we;
    logic [AW-1:0]   query_a;
    logic [AW-1:0]   query_b;
    logic            busy_a;
    logic            busy_b;
`ifdef WB_BYPASS_EN
    logic            fwd_a_valid;
    logic [XLEN-1:0] fwd_a_data;
    logic            fwd_b_valid;
    logic [XLEN-1:0] fwd_b_data;
`endif
    logic            idle;

    int total;
    int passed;
    int fails;

    reg_writeback #(.XLEN(XLEN), .AW(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .lsu_valid   (lsu_valid),
        .lsu_ready   (lsu_ready),
        .lsu_rd      (lsu_rd),
        .lsu_data    (lsu_data),
        .waddr       (waddr),
        .wdata       (wdata),
        .reg_we      (reg_we),
        .query_a     (query_a),
        .query_b     (query_b),
        .busy_a      (busy_a),
        .busy_b      (busy_b),
`ifdef WB_BYPASS_EN
        .fwd_a_valid (fwd_a_valid),
        .fwd_a_data  (fwd_a_data),
        .fwd_b_valid (fwd_b_valid),
        .fwd_b_data  (fwd_b_data),
`endif
        .idle        (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0; passed = 0; fails = 0;
        reset = 1'b0; run = 1'b0;
        issue_valid = 1'b0; issue_rd = '0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
        query_a = '0; query_b = '0;

        // Reset held for two cycles, then released with run=1.
        tick; tick;
        reset = 1'b1; run = 1'b1; query_a = 5'd5;
        #1;
        chk("rst_reg_we", reg_we, 0);
        chk("rst_waddr", waddr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_busy_a", busy_a, 0);
        chk("rst_idle", idle, 1);
        chk("rst_alu_ready", alu_ready, 1);
        chk("rst_lsu_ready", lsu_ready, 1);

        // Issue rd=5, then an ALU result for rd=5.
        issue_valid = 1'b1; issue_rd = 5'd5;
        tick;
        issue_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        #1;
        chk("raw_busy_issued", busy_a, 1);
        chk("raw_alu_ready", alu_ready, 1);
        chk("raw_not_idle", idle, 0);
        tick;
        alu_valid = 1'b0;
        #1;
        chk("raw_busy_buffered", busy_a, 1);
        chk("raw_no_we_c1", reg_we, 0);
        tick; #1;
        chk("raw_we_c2", reg_we, 1);
        chk("raw_waddr_c2", waddr, 5);
        chk("raw_wdata_c2", wdata, 32'hDEADBEEF);
`ifdef WB_BYPASS_EN
        chk("raw_busy_commit", busy_a, 0);
        chk("raw_fwd_valid", fwd_a_valid, 1);
        chk("raw_fwd_data", fwd_a_data, 32'hDEADBEEF);
`else
        chk("raw_busy_commit", busy_a, 1);
`endif
        tick; #1;
        chk("raw_we_after", reg_we, 0);
        chk("raw_busy_after", busy_a, 0);
        chk("raw_idle_after", idle, 1);

        // Contention: ALU rd3/0x11 and LSU rd4/0x22 together; LSU refills with
        // rd6/0x66 while granted, so the next contention goes to the ALU.
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
        lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h22;
        #1;
        chk("arb_alu_ready0", alu_ready, 1);
        chk("arb_lsu_ready0", lsu_ready, 1);
        tick;
        alu_valid = 1'b0;
        lsu_valid = 1'b1; lsu_rd = 5'd6; lsu_data = 32'h66;
        #1;
        chk("arb_no_we_c1", reg_we, 0);
        chk("arb_lsu_granted", lsu_ready, 1);
        chk("arb_alu_waits", alu_ready, 0);
        tick;
        lsu_valid = 1'b0;
        #1;
        chk("arb_first_we", reg_we, 1);
        chk("arb_first_waddr", waddr, 4);
        chk("arb_first_wdata", wdata, 32'h22);
        chk("arb_alu_granted", alu_ready, 1);
        chk("arb_lsu_waits", lsu_ready, 0);
        tick; #1;
        chk("arb_second_we", reg_we, 1);
        chk("arb_second_waddr", waddr, 3);
        chk("arb_second_wdata", wdata, 32'h11);
        tick; #1;
        chk("arb_third_we", reg_we, 1);
        chk("arb_third_waddr", waddr, 6);
        chk("arb_third_wdata", wdata, 32'h66);
        tick; #1;
        chk("arb_done_we", reg_we, 0);
        chk("arb_done_idle", idle, 1);

        // Result to register 0 is accepted and discarded.
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFFFFFF;
        #1;
        chk("r0_alu_ready", alu_ready, 1);
        tick;
        alu_valid = 1'b0;
        #1;
        chk("r0_idle_c1", idle, 1);
        chk("r0_no_we_c1", reg_we, 0);
        tick; #1;
        chk("r0_no_we_c2", reg_we, 0);
        chk("r0_idle_c2", idle, 1);

        // Freeze with a buffered rd=7 result; an issue of rd=8 while frozen is ignored.
        query_a = 5'd7; query_b = 5'd8;
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick;
        issue_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
        tick;
        alu_valid = 1'b0;
        run = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd8;
        #1;
        chk("frz_alu_ready", alu_ready, 0);
        chk("frz_lsu_ready", lsu_ready, 0);
        chk("frz_busy7", busy_a, 1);
        tick; #1;
        chk("frz_no_we", reg_we, 0);
        chk("frz_busy7_held", busy_a, 1);
        chk("frz_issue_ignored", busy_b, 0);
        chk("frz_not_idle", idle, 0);
        tick;
        issue_valid = 1'b0;
        run = 1'b1;
        #1;
        chk("frz_resume_ready", alu_ready, 1);
        chk("frz_resume_no_we", reg_we, 0);
        tick; #1;
        chk("frz_commit_we", reg_we, 1);
        chk("frz_commit_waddr", waddr, 7);
        chk("frz_commit_wdata", wdata, 32'h77);
        tick; #1;
        chk("frz_busy7_clear", busy_a, 0);
        chk("frz_busy8_clear", busy_b, 0);
        chk("frz_idle", idle, 1);

        // Issue rd=9 at the same edge its earlier writeback commits: stays busy.
        query_a = 5'd9;
        issue_valid = 1'b1; issue_rd = 5'd9;
        tick;
        issue_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
        tick;
        alu_valid = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd9;
        tick;
        issue_valid = 1'b0;
        #1;
        chk("same_we", reg_we, 1);
        chk("same_waddr", waddr, 9);
        chk("same_wdata", wdata, 32'h99);
        chk("same_busy_commit", busy_a, 1);
`ifdef WB_BYPASS_EN
        chk("same_fwd_valid", fwd_a_valid, 1);
`endif
        tick; #1;
        chk("same_we_after", reg_we, 0);
        chk("same_busy_kept", busy_a, 1);
        chk("same_not_idle", idle, 0);

        // Reset mid-operation with a buffered rd=10 result and rd=9 busy.
        query_b = 5'd10;
        alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hAA;
        tick;
        alu_valid = 1'b0;
        reset = 1'b0;
        tick;
        reset = 1'b1;
        #1;
        chk("mid_rst_we", reg_we, 0);
        chk("mid_rst_busy9", busy_a, 0);
        chk("mid_rst_idle", idle, 1);
        tick; #1;
        chk("mid_rst_no_write", reg_we, 0);
        chk("mid_rst_idle2", idle, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
